// File: rtl/sop_pkg.sv
// Shared types and constants for the SoP minterm extractor.
// Imported by the extractor top and its last-minterm detector.
package sop_pkg;

   localparam int N_VARS_DEF = 4;
   localparam int ROWS = 2**N_VARS_DEF;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      EMIT,
      DONE
   } state_t;

endpackage

// File: rtl/sop_last_detect.sv
// Flags that no mask bit above ptr is set.
// The extractor uses it to mark the final minterm beat.
module sop_last_detect
   import sop_pkg::*;
#(
   parameter int N_VARS = N_VARS_DEF
) (
   input  logic [2**N_VARS-1:0] i_mask,
   input  logic [N_VARS-1:0]    i_ptr,
   output logic                 o_none_above
);

   logic [2**N_VARS-1:0] w_shift;

   assign w_shift      = i_mask >> i_ptr;
   assign o_none_above = ~|w_shift[2**N_VARS-1:1];

endmodule

// File: rtl/sop_minterm_extractor.sv
// Sweeps all rows of an attached function, captures its truth
// table, then streams the true minterm indices over valid/ready.
module sop_minterm_extractor
   import sop_pkg::*;
#(
   parameter int N_VARS = N_VARS_DEF,
   parameter int SETTLE = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [N_VARS-1:0]    idx_out,
   input  logic                 f_in,
   output logic                 busy,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [N_VARS-1:0]    m_index,
   output logic                 m_last,
   output logic                 done,
   output logic [2**N_VARS-1:0] mask,
   output logic [N_VARS:0]      count
);

   localparam int R = 2**N_VARS;
   localparam logic [N_VARS-1:0] LAST_IDX = '1;
   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_VARS-1:0] r_idx;
   logic [N_VARS-1:0] r_ptr;
   logic [3:0]        r_settle;
   logic [R-1:0]      r_mask;
   logic [N_VARS:0]   r_count;
   logic [N_VARS:0]   w_count_nxt;
   logic              w_sample;
   logic              w_sweep_end;
   logic              w_valid;
   logic              w_none_above;
   logic              w_last;
   logic              w_accept;

   assign w_sample    = (r_state == SWEEP) && (r_settle == SETTLE_L);
   assign w_sweep_end = w_sample && (r_idx == LAST_IDX);
   assign w_count_nxt = r_count + {{N_VARS{1'b0}}, f_in};
   assign w_valid     = (r_state == EMIT) && r_mask[r_ptr];
   assign w_last      = w_valid && w_none_above;
   assign w_accept    = w_valid && m_ready;

   sop_last_detect #(
      .N_VARS(N_VARS)
   ) u_last (
      .i_mask      (r_mask),
      .i_ptr       (r_ptr),
      .o_none_above(w_none_above)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:  if (start) w_state_nxt = SWEEP;
         SWEEP: begin
            if (w_sweep_end)
               w_state_nxt = (w_count_nxt == '0) ? DONE : EMIT;
         end
         EMIT:  if (w_accept && w_last) w_state_nxt = DONE;
         DONE:  w_state_nxt = IDLE;
      endcase
   end

   // A beat holds ptr until accepted; empty rows advance every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx    <= '0;
         r_ptr    <= '0;
         r_settle <= '0;
         r_mask   <= '0;
         r_count  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx    <= '0;
                  r_ptr    <= '0;
                  r_settle <= '0;
                  r_mask   <= '0;
                  r_count  <= '0;
               end
            end
            SWEEP: begin
               if (w_sample) begin
                  r_mask[r_idx] <= f_in;
                  r_count       <= w_count_nxt;
                  if (r_idx == LAST_IDX) begin
                     r_ptr <= '0;
                  end else begin
                     r_idx    <= r_idx + 1'b1;
                     r_settle <= '0;
                  end
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            EMIT: begin
               if (!w_valid || (m_ready && !w_last))
                  r_ptr <= r_ptr + 1'b1;
            end
            DONE: begin
            end
         endcase
      end
   end

   assign idx_out = r_idx;
   assign busy    = (r_state != IDLE);
   assign m_valid = w_valid;
   assign m_index = r_ptr;
   assign m_last  = w_last;
   assign done    = (r_state == DONE);
   assign mask    = r_mask;
   assign count   = r_count;

endmodule

// File: tb/tb_sop_minterm_extractor.sv
// Directed bench for sop_minterm_extractor with a minterm scoreboard.
// Drives a canonical SoP function and a delayed copy as the load.
module tb_sop_minterm_extractor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  idx_out;
   logic        f_in;
   logic        busy;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_index;
   logic        m_last;
   logic        done;
   logic [15:0] mask;
   logic [4:0]  count;

   logic        start2;
   logic [3:0]  idx2;
   logic        f2;
   logic        busy2;
   logic        m_valid2;
   logic [3:0]  m_index2;
   logic        m_last2;
   logic        done2;
   logic [15:0] mask2;
   logic [4:0]  count2;
   logic        f2_d1;
   logic        f2_d2;

   logic [1:0]  fsel;
   int          checks = 0;
   int          errors = 0;
   int          beats = 0;
   int          exp_q[$];

   always #5 clk = ~clk;

   function automatic logic sop_f(input logic [3:0] v);
      return (v[3] & ~v[2] & v[1]) | (v[3] & v[2] & ~v[1]);
   endfunction

   assign f_in = (fsel == 2'd0) ? sop_f(idx_out) : (fsel == 2'd2);

   always @(posedge clk) begin
      f2_d1 <= sop_f(idx2);
      f2_d2 <= f2_d1;
   end
   assign f2 = f2_d2;

   sop_minterm_extractor #(.N_VARS(4), .SETTLE(0)) dut (
      .clk(clk), .reset(reset), .start(start), .idx_out(idx_out),
      .f_in(f_in), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
      .m_index(m_index), .m_last(m_last), .done(done), .mask(mask),
      .count(count)
   );

   sop_minterm_extractor #(.N_VARS(4), .SETTLE(3)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .idx_out(idx2),
      .f_in(f2), .busy(busy2), .m_valid(m_valid2), .m_ready(1'b1),
      .m_index(m_index2), .m_last(m_last2), .done(done2), .mask(mask2),
      .count(count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int enc(input int idx, input bit last);
      return idx * 2 + int'(last);
   endfunction

   // Scoreboard: every accepted beat must match the queue head.
   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) begin
         int e;
         beats++;
         chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_index", 32'(m_index), 32'(e / 2));
            chk("beat_last", 32'(m_last), 32'(e % 2));
         end
      end
   end

   task automatic push_sop();
      exp_q.push_back(enc(10, 0));
      exp_q.push_back(enc(11, 0));
      exp_q.push_back(enc(12, 0));
      exp_q.push_back(enc(13, 1));
   endtask

   task automatic pulse(input bit second);
      if (second) start2 = 1'b1;
      else        start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic run_to_done(input bit second, input int limit,
                              output int cyc, output int nb);
      cyc = 0;
      nb  = 0;
      while (cyc <= limit) begin
         if (second ? busy2 : busy) nb++;
         if (second ? done2 : done) break;
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_seen", 32'(second ? done2 : done), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_idx"}, 32'(idx_out), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
      chk({tag, "_mindex"}, 32'(m_index), 32'd0);
      chk({tag, "_mlast"}, 32'(m_last), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_mask"}, 32'(mask), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
   endtask

   initial begin
      int cyc;
      int nb;
      int base;
      int k;
      reset   = 1'b1;
      start   = 1'b0;
      start2  = 1'b0;
      m_ready = 1'b1;
      fsel    = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("rst");
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: canonical SoP, ready high
      push_sop();
      base = beats;
      pulse(0);
      run_to_done(0, 200, cyc, nb);
      chk("t1_cycles", 32'(cyc), 32'd30);
      chk("t1_busy_len", 32'(nb), 32'd31);
      chk("t1_mask", 32'(mask), 32'h3C00);
      chk("t1_count", 32'(count), 32'd4);
      chk("t1_idx_hold", 32'(idx_out), 32'hF);
      chk("t1_beats", 32'(beats - base), 32'd4);
      chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_mask_hold", 32'(mask), 32'h3C00);

      // 2: function tied low
      fsel = 2'd1;
      base = beats;
      pulse(0);
      run_to_done(0, 200, cyc, nb);
      chk("t2_cycles", 32'(cyc), 32'd16);
      chk("t2_busy_len", 32'(nb), 32'd17);
      chk("t2_mask", 32'(mask), 32'd0);
      chk("t2_count", 32'(count), 32'd0);
      chk("t2_beats", 32'(beats - base), 32'd0);
      @(posedge clk); #1;

      // 3: function tied high
      fsel = 2'd2;
      for (int i = 0; i < 16; i++) exp_q.push_back(enc(i, i == 15));
      base = beats;
      pulse(0);
      run_to_done(0, 200, cyc, nb);
      chk("t3_cycles", 32'(cyc), 32'd32);
      chk("t3_mask", 32'(mask), 32'hFFFF);
      chk("t3_count", 32'(count), 32'd16);
      chk("t3_beats", 32'(beats - base), 32'd16);
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // 4: backpressure while index 11 is offered
      fsel = 2'd0;
      push_sop();
      base = beats;
      pulse(0);
      k = 0;
      while (!(m_valid && m_index == 4'd11) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("t4_reach11", 32'(m_index), 32'd11);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 32'(m_valid), 32'd1);
         chk("t4_hold_index", 32'(m_index), 32'd11);
         chk("t4_hold_last", 32'(m_last), 32'd0);
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      run_to_done(0, 200, cyc, nb);
      chk("t4_beats", 32'(beats - base), 32'd4);
      chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // 5: reset during EMIT after two beats, then replay
      push_sop();
      base = beats;
      pulse(0);
      k = 0;
      while (beats < base + 2 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("t5_two_beats", 32'(beats - base), 32'd2);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outs("t5");
      exp_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      push_sop();
      base = beats;
      pulse(0);
      run_to_done(0, 200, cyc, nb);
      chk("t5_cycles", 32'(cyc), 32'd30);
      chk("t5_mask", 32'(mask), 32'h3C00);
      chk("t5_beats", 32'(beats - base), 32'd4);
      chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // 6: SETTLE=3 with a two-register delayed load, stray start
      pulse(1);
      repeat (9) @(posedge clk);
      #1;
      chk("t6_busy", 32'(busy2), 32'd1);
      pulse(1);
      run_to_done(1, 400, cyc, nb);
      chk("t6_cycles", 32'(cyc), 32'd68);
      chk("t6_mask", 32'(mask2), 32'h3C00);
      chk("t6_count", 32'(count2), 32'd4);
      chk("t6_idx_hold", 32'(idx2), 32'hF);
      @(posedge clk); #1;
      chk("t6_idle", 32'(busy2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
